// File: rtl/mrd_sched_pkg.sv
// Shared types and constants for the mixed-radix DFT stage scheduler.
// Radix codes carry the plain radix value so they drive stg_radix directly.
package mrd_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FACTOR = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [2:0] RDX2 = 3'd2;
  localparam logic [2:0] RDX3 = 3'd3;
  localparam logic [2:0] RDX4 = 3'd4;
  localparam logic [2:0] RDX5 = 3'd5;

  localparam int MAX_STAGES_DEF = 6;

  typedef struct packed {
    logic [2:0] radix;
  } stage_ent_t;

endpackage

// File: rtl/mrd_const_div.sv
// Combinational divide-by-3 and divide-by-5 with exact-division flags.
// Shared between factorisation (on the remainder) and pass issue (on N).
module mrd_const_div #(
  parameter int NW = 12
) (
  input  logic [NW-1:0] a,
  output logic [NW-1:0] q3,
  output logic [NW-1:0] q5,
  output logic          z3,
  output logic          z5
);

  assign q3 = a / NW'(3);
  assign q5 = a / NW'(5);
  assign z3 = (a % NW'(3)) == '0;
  assign z5 = (a % NW'(5)) == '0;

endmodule

// File: rtl/mrd_stage_sched.sv
// Stage scheduler: factorises the DFT length into radix-4/2/3/5 passes and
// hands them to the datapath one at a time with a start/done handshake.
module mrd_stage_sched
  import mrd_sched_pkg::*;
#(
  parameter int MAX_STAGES = MAX_STAGES_DEF,
  parameter int NW         = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [NW-1:0] cfg_dftpts,
  input  logic          cfg_inverse,
  input  logic          cfg_abort,
  output logic          stg_start,
  output logic [2:0]    stg_num,
  output logic [2:0]    stg_radix,
  output logic [NW-1:0] stg_span,
  output logic [NW-1:0] stg_nbfly,
  output logic          stg_last,
  output logic          stg_inverse,
  input  logic          stg_done,
  output logic          frm_done,
  output logic          frm_err,
  output logic          busy
);

  localparam int CW = $clog2(MAX_STAGES + 1);

  state_t        state_reg;
  logic [NW-1:0] rem_reg;
  logic [NW-1:0] n_reg;
  logic          inv_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] k_reg;
  logic [NW-1:0] span_acc_reg;

  logic [NW-1:0] div_in, q3, q5;
  logic          z3, z5;
  logic [2:0]    fac_radix_next;
  logic [NW-1:0] fac_rem_next;
  logic          fac_ok;
  logic          tbl_wr;
  logic [2:0]    cur_radix;
  logic [NW-1:0] nbfly_next;
  stage_ent_t    plan_tab [MAX_STAGES];

  // One divider serves both phases: remainder while factoring, N while issuing.
  assign div_in = (state_reg == FACTOR) ? rem_reg : n_reg;

  mrd_const_div #(.NW(NW)) u_div (
    .a  (div_in),
    .q3 (q3),
    .q5 (q5),
    .z3 (z3),
    .z5 (z5)
  );

  always_comb begin
    fac_radix_next = RDX4;
    fac_rem_next   = rem_reg >> 2;
    fac_ok         = 1'b1;
    if (rem_reg[1:0] == 2'b00) begin
      fac_radix_next = RDX4;
      fac_rem_next   = rem_reg >> 2;
    end else if (!rem_reg[0]) begin
      fac_radix_next = RDX2;
      fac_rem_next   = rem_reg >> 1;
    end else if (z3) begin
      fac_radix_next = RDX3;
      fac_rem_next   = q3;
    end else if (z5) begin
      fac_radix_next = RDX5;
      fac_rem_next   = q5;
    end else begin
      fac_ok = 1'b0;
    end
  end

  assign tbl_wr = (state_reg == FACTOR) && !cfg_abort && (rem_reg != NW'(1)) &&
                  fac_ok && (count_reg != CW'(MAX_STAGES));

  generate
    for (genvar gi = 0; gi < MAX_STAGES; gi++) begin : g_plan
      stage_ent_t ent_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          ent_reg <= '0;
        end else if (tbl_wr && (count_reg == CW'(gi))) begin
          ent_reg <= '{radix: fac_radix_next};
        end
      end
      assign plan_tab[gi] = ent_reg;
    end
  endgenerate

  assign cur_radix = plan_tab[k_reg].radix;

  always_comb begin
    nbfly_next = '0;
    case (cur_radix)
      RDX4:    nbfly_next = n_reg >> 2;
      RDX2:    nbfly_next = n_reg >> 1;
      RDX3:    nbfly_next = q3;
      RDX5:    nbfly_next = q5;
      default: nbfly_next = '0;
    endcase
  end

  assign cfg_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      rem_reg      <= '0;
      n_reg        <= '0;
      inv_reg      <= 1'b0;
      count_reg    <= '0;
      k_reg        <= '0;
      span_acc_reg <= NW'(1);
      stg_start    <= 1'b0;
      stg_num      <= '0;
      stg_radix    <= '0;
      stg_span     <= NW'(1);
      stg_nbfly    <= '0;
      stg_last     <= 1'b0;
      stg_inverse  <= 1'b0;
      frm_done     <= 1'b0;
      frm_err      <= 1'b0;
    end else begin
      stg_start <= 1'b0;
      frm_done  <= 1'b0;
      frm_err   <= 1'b0;
      if (cfg_abort) begin
        state_reg <= IDLE;
        k_reg     <= '0;
        count_reg <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (cfg_valid) begin
              rem_reg      <= cfg_dftpts;
              n_reg        <= cfg_dftpts;
              inv_reg      <= cfg_inverse;
              count_reg    <= '0;
              k_reg        <= '0;
              span_acc_reg <= NW'(1);
              // Zero would divide by 4 forever, so reject it before factoring.
              if (cfg_dftpts == '0) frm_err <= 1'b1;
              else                  state_reg <= FACTOR;
            end
          end
          FACTOR: begin
            if (rem_reg == NW'(1)) begin
              if (count_reg == '0) begin
                frm_err   <= 1'b1;
                state_reg <= IDLE;
              end else begin
                state_reg <= ISSUE;
              end
            end else if (!tbl_wr) begin
              frm_err   <= 1'b1;
              state_reg <= IDLE;
            end else begin
              rem_reg   <= fac_rem_next;
              count_reg <= count_reg + CW'(1);
            end
          end
          ISSUE: begin
            stg_num      <= 3'(k_reg);
            stg_radix    <= cur_radix;
            stg_span     <= span_acc_reg;
            span_acc_reg <= span_acc_reg * NW'(cur_radix);
            stg_nbfly    <= nbfly_next;
            stg_last     <= (k_reg == count_reg - CW'(1));
            stg_inverse  <= inv_reg;
            stg_start    <= 1'b1;
            state_reg    <= WAIT;
          end
          WAIT: begin
            if (stg_done) begin
              if (stg_last) begin
                state_reg <= DONE;
              end else begin
                k_reg     <= k_reg + CW'(1);
                state_reg <= ISSUE;
              end
            end
          end
          DONE: begin
            frm_done  <= 1'b1;
            state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mrd_stage_sched.sv
// Self-checking bench for mrd_stage_sched: table of frame configs, a queue of
// expected passes, and hand-written abort / reset sequences.
module tb_mrd_stage_sched;

  localparam int NW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [NW-1:0] cfg_dftpts;
  logic          cfg_inverse;
  logic          cfg_abort;
  logic          stg_start;
  logic [2:0]    stg_num;
  logic [2:0]    stg_radix;
  logic [NW-1:0] stg_span;
  logic [NW-1:0] stg_nbfly;
  logic          stg_last;
  logic          stg_inverse;
  logic          stg_done;
  logic          frm_done;
  logic          frm_err;
  logic          busy;

  mrd_stage_sched dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_dftpts  (cfg_dftpts),
    .cfg_inverse (cfg_inverse),
    .cfg_abort   (cfg_abort),
    .stg_start   (stg_start),
    .stg_num     (stg_num),
    .stg_radix   (stg_radix),
    .stg_span    (stg_span),
    .stg_nbfly   (stg_nbfly),
    .stg_last    (stg_last),
    .stg_inverse (stg_inverse),
    .stg_done    (stg_done),
    .frm_done    (frm_done),
    .frm_err     (frm_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NW-1:0] n;
    logic          inv;
    logic          err;
    int            err_lat;
    int            ns;
    int            rdx [6];
    int            maxd;
    logic          spur;
  } vec_t;

  typedef struct {
    int num;
    int radix;
    int span;
    int nbfly;
    int last;
    int inv;
  } exp_t;

  exp_t sb [$];
  vec_t vecs [10];
  int   n_cmp = 0;
  int   n_mis = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic vec_t mk(input int n, input int inv, input int err, input int lat,
                              input int ns, input int r0, input int r1, input int r2,
                              input int r3, input int r4, input int r5, input int maxd,
                              input int spur);
    vec_t v;
    v.n = NW'(n); v.inv = inv[0]; v.err = err[0]; v.err_lat = lat; v.ns = ns;
    v.rdx[0] = r0; v.rdx[1] = r1; v.rdx[2] = r2;
    v.rdx[3] = r3; v.rdx[4] = r4; v.rdx[5] = r5;
    v.maxd = maxd; v.spur = spur[0];
    return v;
  endfunction

  task automatic run_frame(input vec_t v, input int abort_pass);
    exp_t          e;
    int            cyc, next_start, done_cyc, done_exp, span;
    logic          fin, stable, in_wait, last_cur, bad;
    logic [2:0]    s_num, s_radix;
    logic [NW-1:0] s_span, s_nbfly;
    logic          s_last, s_inv;
    if (v.spur) begin
      @(negedge clk); stg_done = 1'b1;
      @(negedge clk); stg_done = 1'b0;
      chk("idle_spur_busy", 32'(busy), 0);
      chk("idle_spur_start", 32'(stg_start), 0);
    end
    span = 1;
    for (int i = 0; i < v.ns; i++) begin
      e.num = i; e.radix = v.rdx[i]; e.span = span; e.nbfly = int'(v.n) / v.rdx[i];
      e.last = (i == v.ns - 1) ? 1 : 0; e.inv = int'(v.inv);
      sb.push_back(e);
      span = span * v.rdx[i];
    end
    @(negedge clk);
    chk("ready_pre", 32'(cfg_ready), 1);
    cfg_dftpts = v.n; cfg_inverse = v.inv; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    cyc = 1; fin = 1'b0; in_wait = 1'b0; stable = 1'b1; last_cur = 1'b0;
    next_start = v.err ? -1 : v.ns + 3;
    done_cyc = -10; done_exp = -1;
    s_num = '0; s_radix = '0; s_span = '0; s_nbfly = '0; s_last = 1'b0; s_inv = 1'b0;
    while (!fin && cyc < 3000) begin
      if (stg_start) begin
        chk("start_lat", 32'(cyc), 32'(next_start));
        if (sb.size() == 0) begin
          n_cmp++; n_mis++;
          $display("FAIL unexpected_start: got stg_start num=%0d expected none", stg_num);
          fin = 1'b1;
        end else begin
          e = sb.pop_front();
          chk("num", 32'(stg_num), 32'(e.num));
          chk("radix", 32'(stg_radix), 32'(e.radix));
          chk("span", 32'(stg_span), 32'(e.span));
          chk("nbfly", 32'(stg_nbfly), 32'(e.nbfly));
          chk("last", 32'(stg_last), 32'(e.last));
          chk("inverse", 32'(stg_inverse), 32'(e.inv));
          s_num = stg_num; s_radix = stg_radix; s_span = stg_span;
          s_nbfly = stg_nbfly; s_last = stg_last; s_inv = stg_inverse;
          stable = 1'b1; in_wait = 1'b1; last_cur = (e.last == 1);
          if (abort_pass == e.num) begin
            // Abort and done together: abort must win.
            cfg_abort = 1'b1; stg_done = 1'b1;
            @(negedge clk);
            cfg_abort = 1'b0; stg_done = 1'b0;
            chk("abort_wait_busy", 32'(busy), 0);
            chk("abort_wait_ready", 32'(cfg_ready), 1);
            bad = stg_start;
            repeat (5) begin
              @(negedge clk);
              bad = bad | stg_start | frm_done | frm_err;
            end
            chk("abort_wait_quiet", 32'(bad), 0);
            sb.delete();
            fin = 1'b1;
          end else begin
            done_cyc = cyc + int'($urandom_range(1, v.maxd));
          end
        end
      end else if (in_wait) begin
        if (stg_num != s_num || stg_radix != s_radix || stg_span != s_span ||
            stg_nbfly != s_nbfly || stg_last != s_last || stg_inverse != s_inv)
          stable = 1'b0;
      end
      if (frm_done) begin
        chk("done_lat", 32'(cyc), 32'(done_exp));
        fin = 1'b1;
      end
      if (frm_err) begin
        chk("err_lat", 32'(cyc), v.err ? 32'(v.err_lat) : 32'hFFFF_FFFF);
        fin = 1'b1;
      end
      if (!fin) begin
        stg_done = (cyc == done_cyc) || (v.spur && cyc == done_cyc + 1);
        if (cyc == done_cyc) begin
          chk("wait_stable", 32'(stable), 1);
          in_wait = 1'b0;
          if (last_cur) done_exp = cyc + 2;
          else          next_start = cyc + 2;
        end
        @(negedge clk);
        cyc++;
      end
    end
    stg_done = 1'b0;
    chk("frame_end", 32'(fin), 1);
    chk("sb_empty", 32'(sb.size()), 0);
    sb.delete();
    @(negedge clk);
    chk("ready_post", 32'(cfg_ready), 1);
    chk("busy_post", 32'(busy), 0);
    chk("no_stray_pulse", 32'({stg_start, frm_done, frm_err}), 0);
  endtask

  initial begin
    logic bad, found;
    rst = 1'b1; cfg_valid = 1'b0; cfg_dftpts = '0; cfg_inverse = 1'b0;
    cfg_abort = 1'b0; stg_done = 1'b0;

    //           n     inv err lat ns  r0 r1 r2 r3 r4 r5 maxd spur
    vecs[0] = mk(12,   0,  0,  0,  2,  4, 3, 0, 0, 0, 0, 1,  0);
    vecs[1] = mk(1200, 1,  0,  0,  5,  4, 4, 3, 5, 5, 0, 3,  0);
    vecs[2] = mk(7,    0,  1,  2,  0,  0, 0, 0, 0, 0, 0, 1,  0);
    vecs[3] = mk(0,    0,  1,  1,  0,  0, 0, 0, 0, 0, 0, 1,  0);
    vecs[4] = mk(1,    0,  1,  2,  0,  0, 0, 0, 0, 0, 0, 1,  0);
    vecs[5] = mk(2187, 0,  1,  8,  0,  0, 0, 0, 0, 0, 0, 1,  0);
    vecs[6] = mk(1080, 0,  0,  0,  6,  4, 2, 3, 3, 3, 5, 50, 1);
    vecs[7] = mk(2,    1,  0,  0,  1,  2, 0, 0, 0, 0, 0, 2,  0);
    vecs[8] = mk(3125, 0,  0,  0,  5,  5, 5, 5, 5, 5, 0, 4,  1);
    vecs[9] = mk(36,   0,  0,  0,  3,  4, 3, 3, 0, 0, 0, 2,  0);

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(cfg_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_span", 32'(stg_span), 1);
    chk("rst_outs", 32'({stg_start, stg_num, stg_radix, stg_nbfly, stg_last,
                         stg_inverse, frm_done, frm_err}), 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_frame(vecs[i], -1);

    // Abort while still factoring N=1200.
    @(negedge clk);
    cfg_dftpts = NW'(1200); cfg_inverse = 1'b0; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    @(negedge clk);
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_abort = 1'b0;
    chk("abort_fac_busy", 32'(busy), 0);
    chk("abort_fac_ready", 32'(cfg_ready), 1);
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      bad = bad | stg_start | frm_done | frm_err;
    end
    chk("abort_fac_quiet", 32'(bad), 0);

    run_frame(vecs[1], 2);
    run_frame(vecs[9], -1);

    // Reset in the middle of a WAIT.
    @(negedge clk);
    cfg_dftpts = NW'(12); cfg_inverse = 1'b1; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (stg_start) found = 1'b1;
      else @(negedge clk);
    end
    chk("rstwait_start", 32'(found), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstwait_busy", 32'(busy), 0);
    chk("rstwait_ready", 32'(cfg_ready), 1);
    chk("rstwait_span", 32'(stg_span), 1);
    chk("rstwait_outs", 32'({stg_start, stg_num, stg_radix, stg_nbfly, stg_last,
                             stg_inverse, frm_done, frm_err}), 0);
    rst = 1'b0;

    run_frame(vecs[0], -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
